// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width and the fetch buffer entry layout.
package riscv_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned IFETCH_WORD_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries with a synchronous clear; head is read from registered storage.
module ifetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop_ok;

    // Status flags and head view.
    always_comb begin
        full   = (cnt_q == CNT_W'(DEPTH));
        empty  = (cnt_q == '0);
        pop_ok = pop & ~empty;
        count  = cnt_q;
        rdata  = mem_q[rd_ptr_q];
    end

    // Storage, pointers and occupancy; clear wins over push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    // The credit scheme upstream must never push into a full buffer without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && full && !pop && !clear));

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the fetch PC, issues credited word reads, buffers responses for decode
// and squashes in-flight reads on a redirect.
module ifetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     FIFO_DEPTH      = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_v_o,
    output logic [XLEN-1:0] imem_adr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rsp_v_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            dec_ready_i,
    output logic            instr_v_q_o,
    output logic [XLEN-1:0] instr_q_o,
    output logic [XLEN-1:0] pc0_q_o,
    input  logic            flush_v_q_i,
    input  logic [XLEN-1:0] flush_pc_q_i,
    output logic            flush_v_q_dly1_o
);

    localparam int unsigned     OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned     CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [XLEN-1:0] STEP  = XLEN'(IFETCH_WORD_BYTES);

    logic             run_q;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_nxt;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_nxt;
    logic [OUT_W-1:0] out_cnt_q, out_cnt_nxt;
    logic [OUT_W-1:0] drop_cnt_q, drop_cnt_nxt;
    logic             flush_dly_q;
    logic [XLEN-1:0]  flush_tgt;
    logic             req_fire;
    logic             rsp_keep;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    fetch_entry_t     fifo_wdata;
    fetch_entry_t     fifo_head;
    logic             unused_bits;

    assign unused_bits = ^{flush_pc_q_i[1:0], fifo_full};

    // Credit check, response filtering and next-state of the PC/counter registers.
    always_comb begin
        flush_tgt    = {flush_pc_q_i[XLEN-1:2], 2'b00};
        imem_req_v_o = run_q & ~flush_v_q_i
                     & (out_cnt_q < OUT_W'(MAX_OUTSTANDING))
                     & ((32'(fifo_cnt) + 32'(out_cnt_q)) < 32'(FIFO_DEPTH));
        imem_adr_o   = fetch_pc_q;
        req_fire     = imem_req_v_o & imem_gnt_i;
        instr_v_q_o  = ~fifo_empty & ~flush_v_q_i & ~flush_dly_q;
        fifo_pop     = instr_v_q_o & dec_ready_i;
        rsp_keep     = imem_rsp_v_i & ~flush_v_q_i & (drop_cnt_q == '0);
        fifo_wdata   = '{instr: imem_rsp_data_i, pc: rsp_pc_q};
        out_cnt_nxt  = out_cnt_q + OUT_W'(req_fire) - OUT_W'(imem_rsp_v_i);

        fetch_pc_nxt = fetch_pc_q;
        rsp_pc_nxt   = rsp_pc_q;
        drop_cnt_nxt = drop_cnt_q;

        if (req_fire) begin
            fetch_pc_nxt = fetch_pc_q + STEP;
        end
        if (rsp_keep) begin
            rsp_pc_nxt = rsp_pc_q + STEP;
        end
        if (imem_rsp_v_i && (drop_cnt_q != '0)) begin
            drop_cnt_nxt = drop_cnt_q - OUT_W'(1);
        end
        // Redirect: everything still in flight after this cycle belongs to the old path.
        if (flush_v_q_i) begin
            fetch_pc_nxt = flush_tgt;
            rsp_pc_nxt   = flush_tgt;
            drop_cnt_nxt = out_cnt_nxt;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q       <= 1'b0;
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            out_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            flush_dly_q <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            fetch_pc_q  <= fetch_pc_nxt;
            rsp_pc_q    <= rsp_pc_nxt;
            out_cnt_q   <= out_cnt_nxt;
            drop_cnt_q  <= drop_cnt_nxt;
            flush_dly_q <= flush_v_q_i;
        end
    end

    // Instruction buffer toward decode.
    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rsp_keep),
        .pop     (fifo_pop),
        .clear   (flush_v_q_i),
        .wdata   (fifo_wdata),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    // Decode-facing views of buffered state.
    always_comb begin
        instr_q_o        = fifo_head.instr;
        pc0_q_o          = fifo_head.pc;
        flush_v_q_dly1_o = flush_dly_q;
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a queue-based model of requests, in-flight reads and buffered instructions.
module tb_ifetch;

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned MAX_OUT = 2;

    logic        clk;
    logic        reset_n;
    logic        imem_req_v_o;
    logic [31:0] imem_adr_o;
    logic        imem_gnt_i;
    logic        imem_rsp_v_i;
    logic [31:0] imem_rsp_data_i;
    logic        dec_ready_i;
    logic        instr_v_q_o;
    logic [31:0] instr_q_o;
    logic [31:0] pc0_q_o;
    logic        flush_v_q_i;
    logic [31:0] flush_pc_q_i;
    logic        flush_v_q_dly1_o;

    int tests;
    int fails;

    // Model state
    bit          m_run;
    bit          m_prev_fl;
    logic [31:0] m_fetch;
    logic [31:0] pend_adr[$];
    bit          pend_drop[$];
    logic [31:0] buf_pc[$];
    logic [31:0] buf_dat[$];

    ifetch dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .imem_req_v_o     (imem_req_v_o),
        .imem_adr_o       (imem_adr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rsp_v_i     (imem_rsp_v_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .dec_ready_i      (dec_ready_i),
        .instr_v_q_o      (instr_v_q_o),
        .instr_q_o        (instr_q_o),
        .pc0_q_o          (pc0_q_o),
        .flush_v_q_i      (flush_v_q_i),
        .flush_pc_q_i     (flush_pc_q_i),
        .flush_v_q_dly1_o (flush_v_q_dly1_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic m_reset();
        m_run     = 1'b0;
        m_prev_fl = 1'b0;
        m_fetch   = 32'h0;
        pend_adr.delete();
        pend_drop.delete();
        buf_pc.delete();
        buf_dat.delete();
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input bit gnt, input bit rsp, input bit rdy, input bit fl, input logic [31:0] tgt);
        bit          exp_req;
        bit          exp_iv;
        bit          rsp_eff;
        bit          dr;
        logic [31:0] a;
        rsp_eff         = rsp && (pend_adr.size() > 0);
        imem_gnt_i      = gnt;
        imem_rsp_v_i    = rsp_eff;
        imem_rsp_data_i = rsp_eff ? mem_word(pend_adr[0]) : 32'h0;
        dec_ready_i     = rdy;
        flush_v_q_i     = fl;
        flush_pc_q_i    = tgt;
        #1;
        exp_req = m_run && !fl && (pend_adr.size() < MAX_OUT)
                  && ((buf_pc.size() + pend_adr.size()) < DEPTH);
        exp_iv  = (buf_pc.size() > 0) && !fl && !m_prev_fl;
        tests++;
        if (imem_req_v_o !== exp_req) begin
            fails++;
            $display("FAIL req_v @%0t: got %b expected %b", $time, imem_req_v_o, exp_req);
        end
        if (exp_req) begin
            tests++;
            if (imem_adr_o !== m_fetch) begin
                fails++;
                $display("FAIL req_adr @%0t: got %h expected %h", $time, imem_adr_o, m_fetch);
            end
        end
        tests++;
        if (instr_v_q_o !== exp_iv) begin
            fails++;
            $display("FAIL instr_v @%0t: got %b expected %b", $time, instr_v_q_o, exp_iv);
        end
        if (exp_iv) begin
            tests++;
            if (pc0_q_o !== buf_pc[0] || instr_q_o !== buf_dat[0]) begin
                fails++;
                $display("FAIL head @%0t: got pc %h instr %h expected pc %h instr %h",
                         $time, pc0_q_o, instr_q_o, buf_pc[0], buf_dat[0]);
            end
        end
        tests++;
        if (flush_v_q_dly1_o !== m_prev_fl) begin
            fails++;
            $display("FAIL flush_dly1 @%0t: got %b expected %b", $time, flush_v_q_dly1_o, m_prev_fl);
        end
        @(posedge clk);
        if (exp_iv && rdy) begin
            void'(buf_pc.pop_front());
            void'(buf_dat.pop_front());
        end
        if (rsp_eff) begin
            a  = pend_adr.pop_front();
            dr = pend_drop.pop_front();
            if (!fl && !dr) begin
                buf_pc.push_back(a);
                buf_dat.push_back(mem_word(a));
            end
        end
        if (exp_req && gnt) begin
            pend_adr.push_back(m_fetch);
            pend_drop.push_back(1'b0);
            m_fetch = m_fetch + 32'd4;
        end
        if (fl) begin
            buf_pc.delete();
            buf_dat.delete();
            foreach (pend_drop[i]) pend_drop[i] = 1'b1;
            m_fetch = {tgt[31:2], 2'b00};
        end
        m_prev_fl = fl;
        m_run     = 1'b1;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        tests++;
        if (imem_req_v_o !== 1'b0 || instr_v_q_o !== 1'b0 || flush_v_q_dly1_o !== 1'b0) begin
            fails++;
            $display("FAIL %s_valids: got req %b iv %b fd %b expected 0 0 0",
                     tag, imem_req_v_o, instr_v_q_o, flush_v_q_dly1_o);
        end
        tests++;
        if (instr_q_o !== 32'h0 || pc0_q_o !== 32'h0) begin
            fails++;
            $display("FAIL %s_data: got instr %h pc %h expected 0 0", tag, instr_q_o, pc0_q_o);
        end
        tests++;
        if (imem_adr_o !== 32'h0) begin
            fails++;
            $display("FAIL %s_adr: got %h expected 00000000", tag, imem_adr_o);
        end
    endtask

    task automatic idle_inputs();
        imem_gnt_i      = 1'b0;
        imem_rsp_v_i    = 1'b0;
        imem_rsp_data_i = 32'h0;
        dec_ready_i     = 1'b0;
        flush_v_q_i     = 1'b0;
        flush_pc_q_i    = 32'h0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_reset();
    endtask

    // Let old-path reads return so later scenarios start with nothing in flight.
    task automatic drain();
        for (int i = 0; i < 20 && pend_adr.size() > 0; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #3;
        check_reset_values("reset");
        release_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_flush();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h10);
        drain();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h102);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_flush_rsp_gnt();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
        drain();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB);
        drain();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        release_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        for (int i = 0; i < 600; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
        end
    endtask

    initial begin
        clk   = 1'b0;
        tests = 0;
        fails = 0;
        m_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_rsp_gnt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
